// File: rtl/div32_seq_pkg.sv
// Shared definitions for the sequential divider: ALU control codes, ALU flag
// bit positions and divider state encodings.
package div32_seq_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_NEGA = 3'd1;
    localparam logic [2:0] ST_NEGB = 3'd2;
    localparam logic [2:0] ST_DIV  = 3'd3;
    localparam logic [2:0] ST_NEGQ = 3'd4;
    localparam logic [2:0] ST_NEGR = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

endpackage

// File: rtl/div32_seq_alu.sv
// ALU32: the shared execute-stage 32-bit ALU (add/sub/and/or) with NZCV flags.
// For subtraction the carry flag means "no borrow".
module ALU32
    import div32_seq_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  ctl,
    output logic [31:0] res,
    output logic [3:0]  flags
);

    logic [31:0] b_eff_s;
    logic [32:0] sum_s;
    logic        arith_s;

    // Result and flag generation for the selected operation.
    always_comb begin
        arith_s = (ctl == ALU_ADD) || (ctl == ALU_SUB);
        b_eff_s = (ctl == ALU_SUB) ? ~b : b;
        sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {32'd0, (ctl == ALU_SUB)};
        case (ctl)
            ALU_ADD: res = sum_s[31:0];
            ALU_SUB: res = sum_s[31:0];
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            default: res = 32'd0;
        endcase
        flags         = 4'd0;
        flags[FLAG_N] = res[31];
        flags[FLAG_Z] = (res == 32'd0);
        flags[FLAG_C] = arith_s ? sum_s[32] : 1'b0;
        flags[FLAG_V] = arith_s ? ((a[31] == b_eff_s[31]) && (res[31] != a[31])) : 1'b0;
    end

endmodule

// File: rtl/div32_seq.sv
// div32_seq: restoring divider that steps one shared ALU32 subtract per cycle.
// Define DIV32_SIGNED_EN to add the magnitude/sign-fix states and honour sgn.
module div32_seq
    import div32_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] dvd,
    input  logic [31:0] dvs,
    input  logic        sgn,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        dz
);

`ifdef DIV32_SIGNED_EN
    localparam logic [2:0] ST_FIRST = ST_NEGA;
    localparam logic [2:0] ST_AFTER = ST_NEGQ;
`else
    localparam logic [2:0] ST_FIRST = ST_DIV;
    localparam logic [2:0] ST_AFTER = ST_DONE;
`endif

    logic [2:0]  state_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] r_r;
    logic [4:0]  cnt_r;
    logic        sgn_r;
    logic        negq_r;
    logic        negr_r;
    logic        dz_r;

    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    logic [31:0] alu_res_s;
    logic [3:0]  alu_flags_s;
    logic [31:0] s_s;
    logic        take_s;
    logic        unused_flags_s;

    ALU32 u_alu (
        .a     (alu_a_s),
        .b     (alu_b_s),
        .ctl   (ALU_SUB),
        .res   (alu_res_s),
        .flags (alu_flags_s)
    );

    // ALU operand steering; the negate states compute 0 - x.
    always_comb begin
        s_s     = {r_r[30:0], a_r[31]};
        alu_a_s = 32'd0;
        alu_b_s = 32'd0;
        case (state_r)
            ST_NEGA: alu_b_s = a_r;
            ST_NEGB: alu_b_s = b_r;
            ST_DIV: begin
                alu_a_s = s_s;
                alu_b_s = b_r;
            end
            ST_NEGQ: alu_b_s = a_r;
            ST_NEGR: alu_b_s = r_r;
            default: alu_b_s = 32'd0;
        endcase
        // r_r[31] is the 33rd bit of the shifted remainder: always >= divisor.
        take_s         = r_r[31] | alu_flags_s[FLAG_C];
        unused_flags_s = ^{alu_flags_s[FLAG_N], alu_flags_s[FLAG_Z], alu_flags_s[FLAG_V]};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            r_r     <= 32'd0;
            cnt_r   <= 5'd0;
            sgn_r   <= 1'b0;
            negq_r  <= 1'b0;
            negr_r  <= 1'b0;
            dz_r    <= 1'b0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            quo     <= 32'd0;
            rem     <= 32'd0;
            dz      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid_i && ready_o) begin
                        b_r     <= dvs;
                        cnt_r   <= 5'd31;
                        sgn_r   <= sgn;
                        negq_r  <= sgn & (dvd[31] ^ dvs[31]);
                        negr_r  <= sgn & dvd[31];
                        ready_o <= 1'b0;
                        if (dvs == 32'd0) begin
                            a_r     <= 32'hFFFF_FFFF;
                            r_r     <= dvd;
                            dz_r    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            a_r     <= dvd;
                            r_r     <= 32'd0;
                            dz_r    <= 1'b0;
                            state_r <= ST_FIRST;
                        end
                    end
                end
                ST_NEGA: begin
                    a_r     <= (sgn_r && a_r[31]) ? alu_res_s : a_r;
                    state_r <= ST_NEGB;
                end
                ST_NEGB: begin
                    b_r     <= (sgn_r && b_r[31]) ? alu_res_s : b_r;
                    state_r <= ST_DIV;
                end
                ST_DIV: begin
                    r_r   <= take_s ? alu_res_s : s_s;
                    a_r   <= {a_r[30:0], take_s};
                    cnt_r <= cnt_r - 5'd1;
                    if (cnt_r == 5'd0) begin
                        state_r <= ST_AFTER;
                    end
                end
                ST_NEGQ: begin
                    a_r     <= negq_r ? alu_res_s : a_r;
                    state_r <= ST_NEGR;
                end
                ST_NEGR: begin
                    r_r     <= negr_r ? alu_res_s : r_r;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    if (!valid_o) begin
                        valid_o <= 1'b1;
                        quo     <= a_r;
                        rem     <= r_r;
                        dz      <= dz_r;
                    end else if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed vector table, corner sequences
// (reset abort, consumer stall, back-to-back) and random ops vs. a model.
module tb_div32_seq;

`ifdef DIV32_SIGNED_EN
    localparam bit SGN_BUILD = 1'b1;
    localparam int LAT = 37;
`else
    localparam bit SGN_BUILD = 1'b0;
    localparam int LAT = 33;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] dvd = 32'd0;
    logic [31:0] dvs = 32'd0;
    logic        sgn = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dz;

    int checks = 0;
    int failures = 0;

    div32_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .dvd     (dvd),
        .dvs     (dvs),
        .sgn     (sgn),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .quo     (quo),
        .rem     (rem),
        .dz      (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: plain integer division; signed path uses 64-bit arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (SGN_BUILD && s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n;
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            check("ready_timeout", {31'd0, ready_o}, 32'd1);
        end
        valid_i = 1'b1;
        dvd = a;
        dvs = b;
        sgn = s;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_result();
        ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input vec_t v, input logic check_lat);
        int lat;
        start_op(v.a, v.b, v.s);
        wait_valid(lat);
        if (check_lat) begin
            check({tag, "_lat"}, lat, v.z ? 32'd1 : LAT);
        end
        check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        check({tag, "_quo"}, quo, v.q);
        check({tag, "_rem"}, rem, v.r);
        check({tag, "_dz"}, {31'd0, dz}, {31'd0, v.z});
        take_result();
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int lat;
        int seen;
        logic [31:0] hq;
        logic [31:0] hr;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        vecs.push_back('{a: 32'd100,        b: 32'd7,          s: 1'b0, q: 32'd14,         r: 32'd2,          z: 1'b0});
        vecs.push_back('{a: 32'hFFFF_FFFF,  b: 32'h8000_0000,  s: 1'b0, q: 32'd1,          r: 32'h7FFF_FFFF,  z: 1'b0});
        vecs.push_back('{a: 32'h0000_1234,  b: 32'd0,          s: 1'b0, q: 32'hFFFF_FFFF,  r: 32'h0000_1234,  z: 1'b1});
        vecs.push_back('{a: 32'd0,          b: 32'd5,          s: 1'b0, q: 32'd0,          r: 32'd0,          z: 1'b0});
        vecs.push_back('{a: 32'd7,          b: 32'd9,          s: 1'b0, q: 32'd0,          r: 32'd7,          z: 1'b0});
        vecs.push_back('{a: 32'hFFFF_FFFF,  b: 32'd1,          s: 1'b0, q: 32'hFFFF_FFFF,  r: 32'd0,          z: 1'b0});
        vecs.push_back('{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  s: 1'b0, q: 32'd1,          r: 32'd0,          z: 1'b0});
`ifdef DIV32_SIGNED_EN
        vecs.push_back('{a: 32'hFFFF_FFF9,  b: 32'd2,          s: 1'b1, q: 32'hFFFF_FFFD,  r: 32'hFFFF_FFFF,  z: 1'b0});
        vecs.push_back('{a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  s: 1'b1, q: 32'h8000_0000,  r: 32'd0,          z: 1'b0});
        vecs.push_back('{a: 32'd7,          b: 32'hFFFF_FFFE,  s: 1'b1, q: 32'hFFFF_FFFD,  r: 32'd1,          z: 1'b0});
`else
        vecs.push_back('{a: 32'hFFFF_FFF9,  b: 32'd2,          s: 1'b1, q: 32'h7FFF_FFFC,  r: 32'd1,          z: 1'b0});
        vecs.push_back('{a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  s: 1'b1, q: 32'd0,          r: 32'h8000_0000,  z: 1'b0});
`endif

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_quo", quo, 32'd0);
        check("rst_rem", rem, 32'd0);
        check("rst_dz", {31'd0, dz}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_and_check($sformatf("vec%0d", i), vecs[i], 1'b1);
            check($sformatf("vec%0d_ready_after", i), {31'd0, ready_o}, 32'd1);
            check($sformatf("vec%0d_valid_after", i), {31'd0, valid_o}, 32'd0);
        end

        // Reset in the middle of 100/7 aborts it.
        start_op(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready", {31'd0, ready_o}, 32'd1);
        check("abort_valid", {31'd0, valid_o}, 32'd0);
        check("abort_quo", quo, 32'd0);
        seen = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        check("abort_no_valid", seen, 32'd0);

        // Consumer stalls 5 cycles; outputs must hold.
        start_op(32'd1000, 32'd33, 1'b0);
        wait_valid(lat);
        check("stall_lat", lat, LAT);
        hq = quo;
        hr = rem;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, valid_o}, 32'd1);
            check("stall_quo", quo, 32'd30);
            check("stall_rem", rem, 32'd10);
            check("stall_ready", {31'd0, ready_o}, 32'd0);
        end
        check("stall_hold_quo", quo, hq);
        check("stall_hold_rem", rem, hr);
        take_result();
        check("b2b_ready", {31'd0, ready_o}, 32'd1);
        v = '{a: 32'd81, b: 32'd9, s: 1'b0, q: 32'd9, r: 32'd0, z: 1'b0};
        run_and_check("b2b", v, 1'b1);

        // Randomized operations against the model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 255));
                2: rb = $urandom | 32'h8000_0000;
                3: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if (rb == 32'd0 && ($urandom_range(0, 1) == 0)) rb = 32'd3;
            rs = 1'($urandom_range(0, 1));
            v.a = ra;
            v.b = rb;
            v.s = rs;
            model(ra, rb, rs, v.q, v.r, v.z);
            run_and_check($sformatf("rnd%0d", i), v, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
